async_receiver: RTL

//  UART receive side of the FPGA board's host serial link. It deserialises 8N1 frames from the host

---
 rtl/async_receiver.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/async_receiver.sv
// UART 8N1 receiver: oversample-tick timing, 2-flop input sync, majority-style saturating filter,
// mid-bit sampling FSM, line-idle detection and end-of-packet pulse.
module async_receiver #(
  parameter int ClkFrequency = 69118054,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8,
  parameter int IdleBits     = 10
) (
  input  logic       clk,
  input  logic       arst_l,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_idle,
  output logic       RxD_endofpacket,
  output logic [2:0] dbg_state_o
);

  localparam int Div    = (ClkFrequency + Baud * Oversampling / 2) / (Baud * Oversampling);
  localparam int TickW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int OsW    = $clog2(Oversampling);
  localparam int GapMax = IdleBits * Oversampling;
  localparam int GapW   = $clog2(GapMax + 1);

  localparam logic [TickW-1:0] TickLast = TickW'(Div - 1);
  localparam logic [OsW-1:0]   OsHalf   = OsW'(Oversampling / 2 - 1);
  localparam logic [OsW-1:0]   OsLast   = OsW'(Oversampling - 1);
  localparam logic [GapW-1:0]  GapFull  = GapW'(GapMax);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  // Reset is asserted asynchronously but released on a clock edge.
  logic rst_meta_q;
  logic rst_n_q;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  logic [1:0]       sync_q;
  logic             rx_s;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [1:0]       filt_q, filt_d;
  logic             bit_f_q, bit_f_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             idle_d;

  state_e           state_q;
  logic [OsW-1:0]   os_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shreg_q;
  logic             armed_q;

  assign rx_s        = sync_q[1];
  assign dbg_state_o = state_q;

  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Hysteresis filter: bit_f only flips once the counter hits a rail.
  always_comb begin
    filt_d  = filt_q;
    bit_f_d = bit_f_q;
    if (tick) begin
      if (rx_s && (filt_q != 2'd3)) begin
        filt_d = filt_q + 1'b1;
      end else if (!rx_s && (filt_q != 2'd0)) begin
        filt_d = filt_q - 1'b1;
      end
      if (filt_d == 2'd3) begin
        bit_f_d = 1'b1;
      end else if (filt_d == 2'd0) begin
        bit_f_d = 1'b0;
      end
    end
  end

  always_comb begin
    gap_d = gap_q;
    if (tick) begin
      if ((state_q != S_IDLE) || !bit_f_q) begin
        gap_d = '0;
      end else if (gap_q != GapFull) begin
        gap_d = gap_q + 1'b1;
      end
    end
    idle_d = (gap_d == GapFull);
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      filt_q     <= 2'd3;
      bit_f_q    <= 1'b1;
      gap_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], RxD};
      tick_cnt_q <= tick_cnt_d;
      filt_q     <= filt_d;
      bit_f_q    <= bit_f_d;
      gap_q      <= gap_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q         <= S_IDLE;
      os_q            <= '0;
      bitcnt_q        <= '0;
      shreg_q         <= '0;
      armed_q         <= 1'b0;
      RxD_data        <= '0;
      RxD_data_ready  <= 1'b0;
      RxD_frame_err   <= 1'b0;
      RxD_idle        <= 1'b0;
      RxD_endofpacket <= 1'b0;
    end else begin
      RxD_data_ready  <= 1'b0;
      RxD_frame_err   <= 1'b0;
      RxD_endofpacket <= 1'b0;
      RxD_idle        <= idle_d;
      if (idle_d && !RxD_idle && armed_q) begin
        RxD_endofpacket <= 1'b1;
        armed_q         <= 1'b0;
      end
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!bit_f_q) begin
              state_q <= S_START;
              os_q    <= '0;
            end
          end
          S_START: begin
            if (os_q == OsHalf) begin
              if (bit_f_q) begin
                state_q <= S_IDLE;
              end else begin
                state_q  <= S_DATA;
                bitcnt_q <= '0;
                os_q     <= '0;
              end
            end else begin
              os_q <= os_q + 1'b1;
            end
          end
          S_DATA: begin
            if (os_q == OsLast) begin
              os_q     <= '0;
              shreg_q  <= {bit_f_q, shreg_q[7:1]};
              bitcnt_q <= bitcnt_q + 1'b1;
              if (bitcnt_q == 3'd7) begin
                state_q <= S_STOP;
              end
            end else begin
              os_q <= os_q + 1'b1;
            end
          end
          S_STOP: begin
            if (os_q == OsLast) begin
              os_q <= '0;
              if (bit_f_q) begin
                RxD_data       <= shreg_q;
                RxD_data_ready <= 1'b1;
                armed_q        <= 1'b1;
                state_q        <= S_IDLE;
              end else begin
                RxD_frame_err <= 1'b1;
                state_q       <= S_BREAK;
              end
            end else begin
              os_q <= os_q + 1'b1;
            end
          end
          // A held-low line stays here so it reports a single frame error.
          S_BREAK: begin
            if (bit_f_q) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
